// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared definitions for the iterative multiply/divide unit.
//   OP_*       OpE encodings (MULT, MULTU, DIV, DIVU)
//   state_e    FSM states S_IDLE / S_CALC / S_FIX
//   DIV0_LO    LO value written on divide-by-zero (slice to XLEN)
//   isDivOp / isSignedOp   decode helpers for OpE
package muldiv_pkg;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_e;

    // Wide enough for any supported XLEN; users slice the low XLEN bits.
    localparam logic [63:0] DIV0_LO = '1;

    function automatic logic isDivOp(input logic [1:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic isSignedOp(input logic [1:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// muldiv_if: E-stage request/response bundle of the multiply/divide unit.
//   Pipeline -> unit : StartE, OpE, SrcAE, SrcBE, MtHiE, MtLoE, FlushE, HiLoReadD, MulDivD
//   Unit -> pipeline : Hi, Lo, BusyE, StallReq
//   modport master : pipeline / hazard side
//   modport slave  : muldiv_unit side
interface muldiv_if #(
    parameter int unsigned XLEN = 32
);
    logic            StartE;
    logic [1:0]      OpE;
    logic [XLEN-1:0] SrcAE;
    logic [XLEN-1:0] SrcBE;
    logic            MtHiE;
    logic            MtLoE;
    logic            FlushE;
    logic            HiLoReadD;
    logic            MulDivD;
    logic [XLEN-1:0] Hi;
    logic [XLEN-1:0] Lo;
    logic            BusyE;
    logic            StallReq;

    modport master (
        output StartE, OpE, SrcAE, SrcBE, MtHiE, MtLoE, FlushE, HiLoReadD, MulDivD,
        input  Hi, Lo, BusyE, StallReq
    );

    modport slave (
        input  StartE, OpE, SrcAE, SrcBE, MtHiE, MtLoE, FlushE, HiLoReadD, MulDivD,
        output Hi, Lo, BusyE, StallReq
    );

endinterface

// File: rtl/muldiv_step.sv
// muldiv_step: one combinational radix-2 iteration on unsigned magnitudes.
//   acc      in  2*XLEN  multiply: {partial product, remaining multiplier}
//                        divide:   {partial remainder, remaining dividend/quotient}
//   operand  in  XLEN    multiplicand (multiply) or divisor (divide)
//   isDiv    in  1       0 = shift-add multiply, 1 = restoring shift-subtract divide
//   accNext  out 2*XLEN  accumulator after this iteration
module muldiv_step #(
    parameter int unsigned XLEN = 32
) (
    input  logic [2*XLEN-1:0] acc,
    input  logic [XLEN-1:0]   operand,
    input  logic              isDiv,
    output logic [2*XLEN-1:0] accNext
);

    logic [XLEN:0] sum;
    logic [XLEN:0] partial;
    logic [XLEN:0] diff;

    always_comb begin
        // Multiply: add multiplicand into the upper half when the current
        // multiplier bit is set, then shift the whole accumulator right.
        sum     = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, operand} : '0);
        // Divide: bring in the next dividend bit, trial-subtract the divisor.
        // The remainder is always below the divisor, so XLEN+1 bits suffice
        // and the MSB of diff is the borrow.
        partial = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
        diff    = partial - {1'b0, operand};
        if (isDiv) begin
            if (diff[XLEN]) begin
                accNext = {partial[XLEN-1:0], acc[XLEN-2:0], 1'b0};
            end else begin
                accNext = {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
            end
        end else begin
            accNext = {sum, acc[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO registers.
//   clk    in  rising-edge clock
//   rst_n  in  asynchronous active-low reset (clears HI/LO, aborts any operation)
//   bus    muldiv_if.slave: E-stage request, MTHI/MTLO, flush, decode hazard inputs;
//          Hi/Lo/BusyE/StallReq outputs
// Operation: IDLE -> CALC (XLEN steps) -> FIX (sign fix, HI/LO write) -> IDLE.
// Optional build macro MULDIV_EARLY_OUT_EN: a zero multiply operand or zero divisor
// skips CALC, giving one busy cycle instead of XLEN+1.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic   clk,
    input  logic   rst_n,
    muldiv_if.slave bus
);

    state_e              stateQ, stateD;
    logic [CNT_W-1:0]    cntQ, cntD;
    logic [2*XLEN-1:0]   accQ, accD;
    logic [XLEN-1:0]     operandQ, operandD;
    logic [XLEN-1:0]     dividendQ, dividendD;
    logic                isDivQ, isDivD;
    logic                signAQ, signAD;
    logic                signBQ, signBD;
    logic                divZeroQ, divZeroD;
    logic [XLEN-1:0]     hiQ, hiD;
    logic [XLEN-1:0]     loQ, loD;

    logic                idle;
    logic                startAcc;
    logic                mtWr;
    logic                negA, negB;
    logic [XLEN-1:0]     absA, absB;
    logic                earlyOut;
    logic [2*XLEN-1:0]   stepAcc;
    logic [2*XLEN-1:0]   product;
    logic [XLEN-1:0]     quotient, remainder;
    logic [XLEN-1:0]     resHi, resLo;

    assign idle     = (stateQ == S_IDLE);
    assign startAcc = bus.StartE & ~bus.FlushE & idle;
    assign mtWr     = idle & ~bus.FlushE;

    assign negA = isSignedOp(bus.OpE) & bus.SrcAE[XLEN-1];
    assign negB = isSignedOp(bus.OpE) & bus.SrcBE[XLEN-1];
    assign absA = negA ? -bus.SrcAE : bus.SrcAE;
    assign absB = negB ? -bus.SrcBE : bus.SrcBE;

`ifdef MULDIV_EARLY_OUT_EN
    assign earlyOut = isDivOp(bus.OpE) ? (bus.SrcBE == '0)
                                       : ((bus.SrcAE == '0) || (bus.SrcBE == '0));
`else
    assign earlyOut = 1'b0;
`endif

    muldiv_step #(
        .XLEN(XLEN)
    ) uStep (
        .acc    (accQ),
        .operand(operandQ),
        .isDiv  (isDivQ),
        .accNext(stepAcc)
    );

    // Sign correction of the magnitude result. Signs are recorded only for
    // signed ops, so unsigned ops pass straight through.
    always_comb begin
        product   = (signAQ ^ signBQ) ? -accQ : accQ;
        quotient  = (signAQ ^ signBQ) ? -accQ[XLEN-1:0] : accQ[XLEN-1:0];
        remainder = signAQ ? -accQ[2*XLEN-1:XLEN] : accQ[2*XLEN-1:XLEN];
        if (isDivQ) begin
            if (divZeroQ) begin
                resHi = dividendQ;
                resLo = DIV0_LO[XLEN-1:0];
            end else begin
                resHi = remainder;
                resLo = quotient;
            end
        end else begin
            resHi = product[2*XLEN-1:XLEN];
            resLo = product[XLEN-1:0];
        end
    end

    always_comb begin
        stateD    = stateQ;
        cntD      = cntQ;
        accD      = accQ;
        operandD  = operandQ;
        dividendD = dividendQ;
        isDivD    = isDivQ;
        signAD    = signAQ;
        signBD    = signBQ;
        divZeroD  = divZeroQ;
        hiD       = hiQ;
        loD       = loQ;
        case (stateQ)
            S_IDLE: begin
                if (startAcc) begin
                    isDivD    = isDivOp(bus.OpE);
                    signAD    = negA;
                    signBD    = negB;
                    divZeroD  = (bus.SrcBE == '0);
                    dividendD = bus.SrcAE;
                    cntD      = '0;
                    if (isDivOp(bus.OpE)) begin
                        accD     = {{XLEN{1'b0}}, absA};
                        operandD = absB;
                    end else begin
                        // Early-out multiply has a zero operand: result is zero.
                        accD     = earlyOut ? '0 : {{XLEN{1'b0}}, absB};
                        operandD = absA;
                    end
                    stateD = earlyOut ? S_FIX : S_CALC;
                end
                if (mtWr && bus.MtHiE) begin
                    hiD = bus.SrcAE;
                end
                if (mtWr && bus.MtLoE) begin
                    loD = bus.SrcAE;
                end
            end
            S_CALC: begin
                accD = stepAcc;
                cntD = cntQ + 1'b1;
                if (cntQ == CNT_W'(XLEN - 1)) begin
                    stateD = S_FIX;
                end
            end
            S_FIX: begin
                hiD    = resHi;
                loD    = resLo;
                stateD = S_IDLE;
            end
            default: begin
                stateD = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateQ    <= S_IDLE;
            cntQ      <= '0;
            accQ      <= '0;
            operandQ  <= '0;
            dividendQ <= '0;
            isDivQ    <= 1'b0;
            signAQ    <= 1'b0;
            signBQ    <= 1'b0;
            divZeroQ  <= 1'b0;
            hiQ       <= '0;
            loQ       <= '0;
        end else begin
            stateQ    <= stateD;
            cntQ      <= cntD;
            accQ      <= accD;
            operandQ  <= operandD;
            dividendQ <= dividendD;
            isDivQ    <= isDivD;
            signAQ    <= signAD;
            signBQ    <= signBD;
            divZeroQ  <= divZeroD;
            hiQ       <= hiD;
            loQ       <= loD;
        end
    end

    assign bus.Hi       = hiQ;
    assign bus.Lo       = loQ;
    assign bus.BusyE    = ~idle;
    assign bus.StallReq = (~idle | startAcc) & (bus.HiLoReadD | bus.MulDivD);

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed bench for muldiv_unit with a cycle-level reference model
// (plain 64-bit arithmetic for results, a busy countdown for timing) checked every
// cycle, plus hand-computed literal expectations.
module tb_muldiv_unit;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    muldiv_if #(.XLEN(32)) bus ();

    muldiv_unit #(
        .XLEN (32),
        .CNT_W(6)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

`ifdef MULDIV_EARLY_OUT_EN
    localparam bit EarlyOutBuild = 1'b1;
`else
    localparam bit EarlyOutBuild = 1'b0;
`endif
    localparam int FullLat = 33;

    int nChecks = 0;
    int nPass   = 0;
    bit cmpEn   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act === exp) nPass++;
        else $display("FAIL %s: got 0x%08h, required 0x%08h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    function automatic logic [63:0] refResult(input logic [1:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] res;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            2'b00: res = 64'(sa * sb);
            2'b01: res = {32'h0, a} * {32'h0, b};
            default: begin
                if (b == 32'h0) begin
                    res = {a, 32'hFFFF_FFFF};
                end else if (op == 2'b11) begin
                    res = {a % b, a / b};
                end else begin
                    q = sa / sb;  // truncates toward zero; -2^31/-1 gives 2^31
                    r = sa % sb;
                    res = {r[31:0], q[31:0]};
                end
            end
        endcase
        return res;
    endfunction

    function automatic int refLatency(input logic [1:0] op, input logic [31:0] a,
                                      input logic [31:0] b);
        bit zeroCase;
        zeroCase = op[1] ? (b == 32'h0) : (a == 32'h0 || b == 32'h0);
        return (EarlyOutBuild && zeroCase) ? 1 : FullLat;
    endfunction

    int          busyLeft;
    logic [31:0] mHi, mLo, pHi, pLo;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busyLeft <= 0;
            mHi      <= 32'h0;
            mLo      <= 32'h0;
        end else if (busyLeft > 0) begin
            busyLeft <= busyLeft - 1;
            if (busyLeft == 1) begin
                mHi <= pHi;
                mLo <= pLo;
            end
        end else if (!bus.FlushE) begin
            if (bus.StartE) begin
                {pHi, pLo} <= refResult(bus.OpE, bus.SrcAE, bus.SrcBE);
                busyLeft   <= refLatency(bus.OpE, bus.SrcAE, bus.SrcBE);
            end
            if (bus.MtHiE) mHi <= bus.SrcAE;
            if (bus.MtLoE) mLo <= bus.SrcAE;
        end
    end

    logic expBusy, expStall;
    always @(negedge clk) begin
        if (cmpEn) begin
            expBusy  = (busyLeft > 0);
            expStall = (expBusy | (bus.StartE & ~bus.FlushE & ~expBusy))
                       & (bus.HiLoReadD | bus.MulDivD);
            check("cyc_hi", bus.Hi, mHi);
            check("cyc_lo", bus.Lo, mLo);
            check("cyc_busy", 32'(bus.BusyE), 32'(expBusy));
            check("cyc_stall", 32'(bus.StallReq), 32'(expStall));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic clearInputs();
        bus.StartE = 1'b0; bus.OpE = 2'b00; bus.SrcAE = '0; bus.SrcBE = '0;
        bus.MtHiE = 1'b0; bus.MtLoE = 1'b0; bus.FlushE = 1'b0;
        bus.HiLoReadD = 1'b0; bus.MulDivD = 1'b0;
    endtask

    // Counts busy cycles until BusyE drops; returns aligned at posedge+1.
    task automatic waitDone(output int n);
        bit done;
        n = 0;
        done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (bus.BusyE) n++;
            else done = 1'b1;
        end
        if (!done) begin
            nChecks++;
            $display("FAIL busy_timeout: BusyE=%b after 200 cycles, required 0", bus.BusyE);
        end
        @(posedge clk);
        #1;
    endtask

    // Issues one operation; hold keeps HiLoReadD high for the whole operation.
    task automatic runOp(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit hold, output int n);
        bus.OpE = op; bus.SrcAE = a; bus.SrcBE = b; bus.StartE = 1'b1;
        bus.HiLoReadD = hold;
        #1;
        if (hold) check("stall_at_start", 32'(bus.StallReq), 32'd1);
        @(posedge clk);
        #1;
        bus.StartE = 1'b0;
        waitDone(n);
        bus.HiLoReadD = 1'b0;
    endtask

    int n;

    initial begin
        clearInputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_hi", bus.Hi, 32'h0);
        check("rst_lo", bus.Lo, 32'h0);
        check("rst_busy", 32'(bus.BusyE), 32'd0);
        rst_n = 1'b1;
        cmpEn = 1'b1;
        @(posedge clk);
        #1;

        // MULT -2 * 3 with an MFHI waiting in Decode
        runOp(2'b00, 32'hFFFF_FFFE, 32'd3, 1'b1, n);
        check("mult_busy_cycles", 32'(n), 32'd33);
        check("mult_hi", bus.Hi, 32'hFFFF_FFFF);
        check("mult_lo", bus.Lo, 32'hFFFF_FFFA);
        check("stall_after_done", 32'(bus.StallReq), 32'd0);

        runOp(2'b11, 32'd100, 32'd7, 1'b0, n);
        check("divu_lo", bus.Lo, 32'd14);
        check("divu_hi", bus.Hi, 32'd2);

        runOp(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0, n);
        check("div_neg_lo", bus.Lo, 32'hFFFF_FFFD);
        check("div_neg_hi", bus.Hi, 32'hFFFF_FFFF);

        runOp(2'b10, 32'd5, 32'd0, 1'b0, n);
        check("div0_busy_cycles", 32'(n), EarlyOutBuild ? 32'd1 : 32'd33);
        check("div0_lo", bus.Lo, 32'hFFFF_FFFF);
        check("div0_hi", bus.Hi, 32'd5);

        runOp(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, n);
        check("div_ovf_lo", bus.Lo, 32'h8000_0000);
        check("div_ovf_hi", bus.Hi, 32'h0);

        runOp(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, n);
        check("multu_hi", bus.Hi, 32'hFFFF_FFFE);
        check("multu_lo", bus.Lo, 32'h0000_0001);

        runOp(2'b00, 32'd0, 32'h1234_5678, 1'b0, n);
        check("mult0_busy_cycles", 32'(n), EarlyOutBuild ? 32'd1 : 32'd33);
        check("mult0_hi", bus.Hi, 32'h0);
        check("mult0_lo", bus.Lo, 32'h0);

        // Start under flush is dropped
        bus.StartE = 1'b1; bus.FlushE = 1'b1; bus.OpE = 2'b00;
        bus.SrcAE = 32'd3; bus.SrcBE = 32'd4; bus.MulDivD = 1'b1;
        #1;
        check("flush_stall", 32'(bus.StallReq), 32'd0);
        @(posedge clk);
        #1;
        clearInputs();
        check("flush_busy", 32'(bus.BusyE), 32'd0);
        check("flush_lo_hold", bus.Lo, 32'h0);

        // MTHI while idle
        bus.MtHiE = 1'b1; bus.SrcAE = 32'h1234_5678;
        @(posedge clk);
        #1;
        bus.MtHiE = 1'b0;
        check("mthi_hi", bus.Hi, 32'h1234_5678);
        check("mthi_lo_hold", bus.Lo, 32'h0);

        // MTHI and MTLO together
        bus.MtHiE = 1'b1; bus.MtLoE = 1'b1; bus.SrcAE = 32'hCAFE_F00D;
        @(posedge clk);
        #1;
        bus.MtHiE = 1'b0; bus.MtLoE = 1'b0;
        check("mthilo_hi", bus.Hi, 32'hCAFE_F00D);
        check("mthilo_lo", bus.Lo, 32'hCAFE_F00D);

        // MTHI while busy is ignored; HI/LO hold until the result lands
        bus.OpE = 2'b11; bus.SrcAE = 32'd100; bus.SrcBE = 32'd7; bus.StartE = 1'b1;
        @(posedge clk);
        #1;
        bus.StartE = 1'b0; bus.MtHiE = 1'b1; bus.SrcAE = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        bus.MtHiE = 1'b0;
        check("mthi_busy_hi_hold", bus.Hi, 32'hCAFE_F00D);
        check("mthi_busy_lo_hold", bus.Lo, 32'hCAFE_F00D);
        waitDone(n);
        check("mthi_busy_hi", bus.Hi, 32'd2);
        check("mthi_busy_lo", bus.Lo, 32'd14);

        // Reset in the middle of CALC
        bus.OpE = 2'b00; bus.SrcAE = 32'd7; bus.SrcBE = 32'd9; bus.StartE = 1'b1;
        @(posedge clk);
        #1;
        bus.StartE = 1'b0;
        repeat (11) @(posedge clk);
        #1;
        check("pre_rst_busy", 32'(bus.BusyE), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_hi", bus.Hi, 32'h0);
        check("midrst_lo", bus.Lo, 32'h0);
        check("midrst_busy", 32'(bus.BusyE), 32'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        runOp(2'b00, 32'd7, 32'd9, 1'b0, n);
        check("restart_busy_cycles", 32'(n), 32'd33);
        check("restart_hi", bus.Hi, 32'h0);
        check("restart_lo", bus.Lo, 32'd63);

        cmpEn = 1'b0;
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide unit in the Execute stage. It owns the HI/LO architectural registers.
- It is the stall-requesting counterpart of the pipeline hazard unit. It consumes FlushE and reports BusyE/StallReq, which the hazard unit folds into StallF/StallD.
- It executes MULT, MULTU, DIV, DIVU over multiple cycles, and MTHI/MTLO in a single cycle.

Parameters:
- XLEN, 32, operand width; HI and LO are each XLEN bits.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > XLEN.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- StartE  in  1  mul/div instruction valid in E
- OpE  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- SrcAE  in  XLEN  rs operand (multiplicand / dividend)
- SrcBE  in  XLEN  rt operand (multiplier / divisor)
- MtHiE  in  1  write SrcAE to HI
- MtLoE  in  1  write SrcAE to LO
- FlushE  in  1  from hazard unit; kills the E-stage instruction this cycle
- HiLoReadD  in  1  MFHI/MFLO in Decode
- MulDivD  in  1  mul/div or MTHI/MTLO in Decode
- Hi  out  XLEN  HI register
- Lo  out  XLEN  LO register
- BusyE  out  1  operation in progress
- StallReq  out  1  to hazard unit; stall F and D

Behaviour:
- Reset (async, rst_n=0): Hi=0, Lo=0, BusyE=0, state IDLE, counter=0. Reset mid-operation aborts immediately and HI/LO are cleared.
- Accept: start_acc = StartE & ~FlushE & state==IDLE.
  - StartE during FlushE is ignored.
  - StartE while not IDLE is ignored. This cannot occur legally because StallReq holds the instruction in D.
- FSM states:
  - IDLE: on start_acc, latch |operands|, record the signs and Op, clear the counter, go to CALC.
  - CALC: one radix-2 step per cycle, for XLEN cycles total.
    - Multiply: shift-add into a 2*XLEN accumulator.
    - Divide: restoring shift-subtract producing quotient and remainder.
    - When counter==XLEN-1, go to FIX.
  - FIX: one cycle. Apply sign correction for signed ops, then write HI/LO and go to IDLE.
    - Product sign = sA^sB.
    - Quotient sign = sA^sB.
    - Remainder sign = sA.
- Latency: BusyE is high for exactly XLEN+1 cycles, starting the cycle after accept. HI/LO show the new value in the first cycle after BusyE falls.
- Result mapping:
  - Multiply: HI = upper XLEN bits, LO = lower XLEN bits.
  - Divide: LO = quotient, HI = remainder.
- Divide by zero: LO = all ones, HI = dividend (SrcAE as given). The full XLEN+1 latency still applies.
- Signed overflow (-2^31 / -1): LO = 0x80000000, HI = 0. No trap.
- MTHI/MTLO:
  - Written at the clock edge when asserted, state==IDLE and ~FlushE.
  - If either is asserted when not IDLE, it is ignored; the hazard unit prevents this case.
  - MtHiE and MtLoE may both be set in the same cycle.
- StallReq (combinational) = (BusyE | start_acc) & (HiLoReadD | MulDivD).
- FlushE while BusyE does not abort the operation, because the instruction has already left E.
- Hi/Lo hold their value throughout an operation. There is no partial update.

Optional Feature:
- MULDIV_EARLY_OUT_EN: when defined, skip CALC if either multiply operand is 0, or if the divide divisor is 0. The unit goes IDLE→FIX, writes the defined result, and BusyE is high for 1 cycle.
- When undefined, every operation takes XLEN+1 busy cycles. There is no data-dependent latency.

Decomposition:
- Shared package, muldiv_pkg:
  - OpE encodings: OP_MULT, OP_MULTU, OP_DIV, OP_DIVU.
  - FSM state enum: S_IDLE, S_CALC, S_FIX.
  - DIV0_LO constant.
- Sub-module muldiv_step: combinational single iteration (add-shift / sub-shift) on accumulator, operand and mode. It is instantiated once; the FSM and registers stay in the top.

Test Plan:
- MULT with SrcAE=0xFFFFFFFE (-2), SrcBE=3 → BusyE high 33 cycles; then Hi=0xFFFFFFFF, Lo=0xFFFFFFFA.
- DIVU with 100 / 7 → Lo=14, Hi=2. DIV with -7 / 2 → Lo=0xFFFFFFFD, Hi=0xFFFFFFFF.
- DIV with 5 / 0 → Lo=0xFFFFFFFF, Hi=5. Busy for 33 cycles without the feature, 1 cycle with it.
- Start with HiLoReadD=1 in the same cycle → StallReq=1 from that cycle until BusyE falls. StartE together with FlushE=1 → BusyE stays 0 and StallReq=0.
- MtHiE=1, SrcAE=0x12345678 while IDLE → Hi=0x12345678 next cycle, Lo unchanged. MtHiE while busy → ignored.
- rst_n pulled low at CALC cycle 10 → Hi=Lo=0 and BusyE=0 immediately. Restart after release completes correctly.
